// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and load/store data,
// with one outstanding transaction, a fetch starvation guard and a memory timeout.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_valid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_be_i,
    output logic        d_valid_o,
    output logic [31:0] d_rdata_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TO_LIM     = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

    state_t        state_q;
    logic [SW-1:0] starve_q;
    logic [TW-1:0] tcnt_q;
    logic          mem_req_q, mem_we_q;
    logic [31:0]   mem_addr_q, mem_wdata_q;
    logic [3:0]    mem_be_q;
    logic          if_valid_q, d_valid_q, err_q;
    logic [31:0]   if_rdata_q, d_rdata_q;

    logic if_elig, d_elig, pick_if, pick_d;

    // A port whose valid is pulsing this cycle is being retired and must not be re-granted.
    always_comb begin
        if_elig = if_req_i && !if_valid_q;
        d_elig  = d_req_i && !d_valid_q;
        pick_if = if_elig && (!d_elig || (starve_q == STARVE_LIM));
        pick_d  = d_elig && !pick_if;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            tcnt_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    tcnt_q <= '0;
                    if (pick_if) begin
                        state_q     <= BUSY_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= '0;
                        mem_be_q    <= 4'hF;
                        starve_q    <= '0;
                    end else if (pick_d) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we_i;
                        mem_addr_q  <= d_addr_i;
                        mem_wdata_q <= d_wdata_i;
                        mem_be_q    <= d_be_i;
                        if (!if_elig) begin
                            starve_q <= '0;
                        end else if (starve_q != STARVE_LIM) begin
                            starve_q <= starve_q + SW'(1);
                        end
                    end
                end
                BUSY_IF, BUSY_D: begin
                    // A ready arriving on the limit cycle wins over the timeout.
                    if (mem_ready_i || (tcnt_q == TO_LIM)) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        tcnt_q    <= '0;
                        err_q     <= !mem_ready_i;
                        if (state_q == BUSY_IF) begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= mem_ready_i ? mem_rdata_i : 32'h0;
                        end else begin
                            d_valid_q <= 1'b1;
                            d_rdata_q <= mem_ready_i ? mem_rdata_i : 32'h0;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_valid_o  = if_valid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_valid_o   = d_valid_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
endmodule
